// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the external memory cycle sequencer:
//   - transfer / memory width encodings (W8..W64)
//   - sequencer state enum
//   - helpers that turn a width pair into beat count, address alignment mask
//     and per-beat byte address step
// -----------------------------------------------------------------------------
package bus_pkg;

    // Width encoding shared by requester transfer width and memory width.
    localparam logic [1:0] W8  = 2'b00;
    localparam logic [1:0] W16 = 2'b01;
    localparam logic [1:0] W32 = 2'b10;
    localparam logic [1:0] W64 = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        WAIT = 2'b10,
        DATA = 2'b11
    } state_t;

    // Number of memory beats needed to move one transfer: a transfer wider
    // than the memory is split into 2^(xfer_w - mem_w) beats (at most 8).
    function automatic logic [3:0] beat_count(input logic [1:0] xfer_w,
                                              input logic [1:0] mem_w);
        if (xfer_w > mem_w)
            return 4'd1 << (xfer_w - mem_w);
        return 4'd1;
    endfunction

    // Byte address bits kept when aligning the start address to the memory
    // width (the low mem_w bits are cleared).
    function automatic logic [2:0] align_mask(input logic [1:0] mem_w);
        case (mem_w)
            W8:      return 3'b111;
            W16:     return 3'b110;
            W32:     return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Byte address increment per beat, modulo 8 (a 64-bit memory never
    // takes a second beat, so its step of 8 folds to 0).
    function automatic logic [2:0] beat_step(input logic [1:0] mem_w);
        case (mem_w)
            W8:      return 3'd1;
            W16:     return 3'd2;
            W32:     return 3'd4;
            W64:     return 3'd0;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: grants the first set request at or
// after ptr, wrapping around.
// Ports:
//   req    in   NREQ   request levels
//   ptr    in   IW     index with highest priority this round
//   gnt    out  NREQ   one-hot grant (all zero when no request)
//   idx    out  IW     binary index of the granted requester
//   valid  out  1      some request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        int              slot;
        logic [IW-1:0]   pos;
        // NOTE: every output gets a default before the search loop so that no
        // path through the block leaves it unassigned, which would infer a latch.
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        slot  = 0;
        pos   = '0;
        for (int i = 0; i < NREQ; i++) begin
            slot = int'(ptr) + i;
            if (slot >= NREQ)
                slot = slot - NREQ;
            pos = IW'(slot);
            if (!valid && req[pos]) begin
                valid    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/bus_cycle_seq.sv
// -----------------------------------------------------------------------------
// bus_cycle_seq
// External memory cycle sequencer. Arbitrates NREQ masters round-robin and
// runs one transfer per grant, split into memory-width beats, with a fixed
// number of wait states per beat.
// Ports:
//   clk      in   1        system clock
//   resetl   in   1        asynchronous active-low reset
//   req      in   NREQ     request levels, held until done
//   reqrd    in   NREQ     1=read, 0=write (captured at grant)
//   reqw     in   2*NREQ   transfer width per requester
//   reqba    in   3*NREQ   start byte address [2:0] per requester
//   mwidth   in   2        addressed memory width (captured at grant)
//   waits    in   WSW      wait states per beat (captured at grant)
//   gnt      out  NREQ     one-hot grant, ADDR through last DATA
//   idle     out  1        no transfer in progress
//   reads    out  1        captured read flag of the granted requester
//   ack      out  1        pulse in ADDR
//   ourack   out  1        pulse per DATA beat
//   ba       out  3        current beat byte address
//   done     out  NREQ     pulse to the granted requester on its last beat
// -----------------------------------------------------------------------------
module bus_cycle_seq
    import bus_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WSW  = 4
) (
    input  logic              clk,
    input  logic              resetl,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   reqrd,
    input  logic [2*NREQ-1:0] reqw,
    input  logic [3*NREQ-1:0] reqba,
    input  logic [1:0]        mwidth,
    input  logic [WSW-1:0]    waits,
    output logic [NREQ-1:0]   gnt,
    output logic              idle,
    output logic              reads,
    output logic              ack,
    output logic              ourack,
    output logic [2:0]        ba,
    output logic [NREQ-1:0]   done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q;
    logic            idle_q;
    logic            reads_q;
    logic [2:0]      ba_q;
    logic [IW-1:0]   ptr_q;
    logic [WSW-1:0]  cnt_q;
    logic [WSW-1:0]  waits_q;
    logic [3:0]      beats_q;
    logic [1:0]      mw_q;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;

    logic            sel_rd;
    logic [1:0]      sel_w;
    logic [2:0]      sel_ba;
    logic            last_beat;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Route the winning requester's attributes.
    always_comb begin
        sel_rd = 1'b0;
        sel_w  = W8;
        sel_ba = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_rd = reqrd[i];
                sel_w  = reqw[2*i +: 2];
                sel_ba = reqba[3*i +: 3];
            end
        end
    end

    assign last_beat = (beats_q == 4'd1);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = ADDR;
            ADDR:    state_d = (waits_q == '0) ? DATA : WAIT;
            // The count holds the remaining wait cycles including this one.
            WAIT:    if (cnt_q <= WSW'(1)) state_d = DATA;
            DATA: begin
                if (last_beat)
                    state_d = IDLE;
                else
                    state_d = (waits_q == '0) ? DATA : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idle_q  <= 1'b1;
            reads_q <= 1'b0;
            ba_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            waits_q <= '0;
            beats_q <= '0;
            mw_q    <= W8;
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // register here samples pre-edge values regardless of statement order.
            state_q <= state_d;
            idle_q  <= (state_d == IDLE);
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        // Capture everything at grant; later input changes
                        // cannot disturb the transfer.
                        gnt_q   <= arb_gnt;
                        reads_q <= sel_rd;
                        ba_q    <= sel_ba & align_mask(mwidth);
                        beats_q <= beat_count(sel_w, mwidth);
                        waits_q <= waits;
                        mw_q    <= mwidth;
                        ptr_q   <= (arb_idx == IW'(NREQ-1)) ? '0 : arb_idx + IW'(1);
                    end
                end
                ADDR: cnt_q <= waits_q;
                WAIT: cnt_q <= cnt_q - WSW'(1);
                DATA: begin
                    if (last_beat) begin
                        gnt_q <= '0;
                    end else begin
                        ba_q    <= ba_q + beat_step(mw_q);
                        beats_q <= beats_q - 4'd1;
                        cnt_q   <= waits_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pulses decoded from registered state only.
    assign ack    = (state_q == ADDR);
    assign ourack = (state_q == DATA);
    assign done   = (ourack && last_beat) ? gnt_q : '0;

    assign gnt    = gnt_q;
    assign idle   = idle_q;
    assign reads  = reads_q;
    assign ba     = ba_q;

endmodule

// File: tb/tb_bus_cycle_seq.sv
// -----------------------------------------------------------------------------
// tb_bus_cycle_seq
// Directed bench for bus_cycle_seq. Inputs change and outputs are sampled on
// the falling clock edge; "sample k" is the k-th falling edge after the rising
// edge on which the idle sequencer first sees the request.
// -----------------------------------------------------------------------------
module tb_bus_cycle_seq;

    localparam int NREQ = 4;
    localparam int WSW  = 4;

    logic              clk = 1'b0;
    logic              resetl;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   reqrd;
    logic [2*NREQ-1:0] reqw;
    logic [3*NREQ-1:0] reqba;
    logic [1:0]        mwidth;
    logic [WSW-1:0]    waits;
    logic [NREQ-1:0]   gnt;
    logic              idle;
    logic              reads;
    logic              ack;
    logic              ourack;
    logic [2:0]        ba;
    logic [NREQ-1:0]   done;

    int n_tests = 0;
    int n_fail  = 0;

    bus_cycle_seq #(.NREQ(NREQ), .WSW(WSW)) dut (
        .clk    (clk),
        .resetl (resetl),
        .req    (req),
        .reqrd  (reqrd),
        .reqw   (reqw),
        .reqba  (reqba),
        .mwidth (mwidth),
        .waits  (waits),
        .gnt    (gnt),
        .idle   (idle),
        .reads  (reads),
        .ack    (ack),
        .ourack (ourack),
        .ba     (ba),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // All outputs at their reset values.
    task automatic check_reset_outs(input string tag);
        check({tag, ".idle"},   32'(idle),   32'h1);
        check({tag, ".gnt"},    32'(gnt),    32'h0);
        check({tag, ".reads"},  32'(reads),  32'h0);
        check({tag, ".ack"},    32'(ack),    32'h0);
        check({tag, ".ourack"}, 32'(ourack), 32'h0);
        check({tag, ".ba"},     32'(ba),     32'h0);
        check({tag, ".done"},   32'(done),   32'h0);
    endtask

    logic [3:0] exp_g [5];

    initial begin
        exp_g[0] = 4'b0001;
        exp_g[1] = 4'b0010;
        exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000;
        exp_g[4] = 4'b0001;

        // ---- 1: reset with all requests pending ----
        resetl = 1'b0;
        req    = 4'b1111;
        reqrd  = '0;
        reqw   = '0;
        reqba  = '0;
        mwidth = 2'b00;
        waits  = '0;
        step(2);
        check_reset_outs("rst");
        resetl = 1'b1;
        step(1);
        check("t1.first_gnt", 32'(gnt), 32'h1);
        check("t1.ack",       32'(ack), 32'h1);
        req = '0;
        step(1);
        check("t1.done", 32'(done), 32'h1);
        step(1);
        check("t1.idle", 32'(idle), 32'h1);

        // ---- 2: 16b read from 16b memory, 2 waits, unaligned start ----
        req    = 4'b0010;
        reqrd  = 4'b0010;
        reqw   = 8'b00_00_01_00;
        mwidth = 2'b01;
        waits  = 4'd2;
        reqba  = 12'b000_000_011_000;
        step(1);
        check("t2.ack_n1",  32'(ack),   32'h1);
        check("t2.gnt",     32'(gnt),   32'h2);
        check("t2.reads",   32'(reads), 32'h1);
        check("t2.idle_n1", 32'(idle),  32'h0);
        step(1);
        check("t2.ack_n2",    32'(ack),    32'h0);
        check("t2.ourack_n2", 32'(ourack), 32'h0);
        step(1);
        check("t2.ourack_n3", 32'(ourack), 32'h0);
        step(1);
        check("t2.ourack_n4", 32'(ourack), 32'h1);
        check("t2.ba_n4",     32'(ba),     32'h2);
        check("t2.done_n4",   32'(done),   32'h2);
        req = '0;
        step(1);
        check("t2.idle_n5", 32'(idle), 32'h1);
        check("t2.done_n5", 32'(done), 32'h0);

        // ---- 3: 64b write to 16b memory, no waits -> 4 back-to-back beats ----
        req    = 4'b0100;
        reqrd  = 4'b0000;
        reqw   = 8'b00_11_00_00;
        mwidth = 2'b01;
        waits  = 4'd0;
        reqba  = '0;
        step(1);
        check("t3.ack",   32'(ack),   32'h1);
        check("t3.reads", 32'(reads), 32'h0);
        for (int b = 0; b < 4; b++) begin
            step(1);
            check($sformatf("t3.ourack_b%0d", b), 32'(ourack), 32'h1);
            check($sformatf("t3.ba_b%0d", b),     32'(ba),     32'(2 * b));
            check($sformatf("t3.done_b%0d", b),   32'(done),   (b == 3) ? 32'h4 : 32'h0);
            if (b == 3)
                req = '0;
        end
        step(1);
        check("t3.idle", 32'(idle), 32'h1);

        // ---- 5: 8b transfer to 64b memory, req dropped in WAIT ----
        req    = 4'b1000;
        reqw   = 8'b00_00_00_00;
        mwidth = 2'b11;
        waits  = 4'd3;
        reqba  = 12'b101_000_000_000;
        step(1);
        check("t5.ack", 32'(ack), 32'h1);
        check("t5.gnt", 32'(gnt), 32'h8);
        step(1);
        // In WAIT: drop the request and disturb the captured parameters.
        req    = '0;
        waits  = 4'd0;
        mwidth = 2'b00;
        step(2);
        check("t5.ourack_wait", 32'(ourack), 32'h0);
        step(1);
        check("t5.ourack", 32'(ourack), 32'h1);
        check("t5.ba",     32'(ba),     32'h0);
        check("t5.done",   32'(done),   32'h8);
        step(1);
        check("t5.ourack_after", 32'(ourack), 32'h0);
        check("t5.idle",         32'(idle),   32'h1);

        // ---- 4: all requests held -> rotating grants with idle gaps ----
        req    = 4'b1111;
        reqw   = '0;
        mwidth = 2'b00;
        waits  = 4'd0;
        reqba  = '0;
        for (int g = 0; g < 5; g++) begin
            step(1);
            check($sformatf("t4.gnt%0d", g),  32'(gnt),  32'(exp_g[g]));
            check($sformatf("t4.ack%0d", g),  32'(ack),  32'h1);
            step(1);
            check($sformatf("t4.done%0d", g), 32'(done), 32'(exp_g[g]));
            if (g == 4)
                req = '0;
            step(1);
            check($sformatf("t4.idle%0d", g),    32'(idle), 32'h1);
            check($sformatf("t4.gap_gnt%0d", g), 32'(gnt),  32'h0);
        end

        // ---- 6: reset during beat 2 of a 4-beat transfer ----
        req    = 4'b0100;
        reqrd  = 4'b0100;
        reqw   = 8'b00_11_00_00;
        mwidth = 2'b01;
        waits  = 4'd0;
        step(1);
        check("t6.ack", 32'(ack), 32'h1);
        step(1);
        check("t6.ba_b1", 32'(ba), 32'h0);
        step(1);
        check("t6.ourack_b2", 32'(ourack), 32'h1);
        check("t6.ba_b2",     32'(ba),     32'h2);
        check("t6.reads",     32'(reads),  32'h1);
        #2;
        resetl = 1'b0;
        #1;
        check_reset_outs("t6.async");
        req = 4'b1111;
        step(1);
        check_reset_outs("t6.held");
        resetl = 1'b1;
        step(1);
        check("t6.next_gnt", 32'(gnt),  32'h1);
        check("t6.no_done",  32'(done), 32'h0);
        req = '0;
        step(2);
        check("t6.idle", 32'(idle), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
